// File: rtl/uart_rcv_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rcv_pkg;

    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        LOAD
    } rcv_state_e;

    // Expected parity bit for a zero-padded payload; odd=1 inverts the even result.
    function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] data,
                                             input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rcv_fifo.sv
// Synchronous show-ahead FIFO: head is the oldest entry, next_head the one behind it.
module rcv_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [WIDTH-1:0]             next_head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign next_head = mem_q[rd_ptr_q + PTR_W'(1)];

    // Pointer and occupancy update; a pop frees a slot for a same-cycle push.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rcv_fifo.sv
// UART frame receiver with mid-bit sampling, error flags and a receive FIFO.
module uart_rcv_fifo
    import uart_rcv_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                serial_in,
    input  logic                                parity_odd,
    input  logic                                data_read,
    output logic [DATA_BITS-1:0]                rx_data,
    output logic                                data_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                framing_error,
    output logic                                parity_error,
    output logic                                overrun_error
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS+1);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

    // Edge detection and the START register each cost a cycle, so the half-bit wait is shortened by two.
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF   = TMR_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);

    rcv_state_e             state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic                   frm_bad_q, frm_bad_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   data_ready_q, data_ready_d;
    logic                   framing_error_q, framing_error_d;
    logic                   parity_error_q, parity_error_d;
    logic                   overrun_q, overrun_d;

    logic                   load_c;
    logic                   tmr_zero_c;
    logic                   good_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   drop_c;
    logic [DATA_BITS-1:0]   fifo_head;
    logic [DATA_BITS-1:0]   fifo_next_head;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign fifo_count    = fifo_cnt;
    assign framing_error = framing_error_q;
    assign parity_error  = parity_error_q;
    assign overrun_error = overrun_q;
    assign tmr_zero_c    = (timer_q == '0);

    // Frame sequencer: start detect, bit sampling and error accumulation.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        frm_bad_d = frm_bad_q;
        load_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    timer_d = TMR_HALF;
                end
            end
            START: begin
                if (tmr_zero_c) begin
                    if (!sync2_q) begin
                        state_d   = DATA;
                        timer_d   = TMR_RELOAD;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                        frm_bad_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DATA: begin
                if (tmr_zero_c) begin
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    timer_d = TMR_RELOAD;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            PARITY: begin
                if (tmr_zero_c) begin
                    par_bad_d = (sync2_q != expected_parity(MAX_DATA_BITS'(shift_q), parity_odd));
                    timer_d   = TMR_RELOAD;
                    state_d   = STOP;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            STOP: begin
                if (tmr_zero_c) begin
                    if (!sync2_q) begin
                        frm_bad_d = 1'b1;
                    end
                    timer_d = TMR_RELOAD;
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            LOAD: begin
                load_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus side: push/pop arbitration, head register and status flags.
    always_comb begin
        pop_c  = data_read && !fifo_empty;
        good_c = load_c && !frm_bad_q && !par_bad_q;
        push_c = good_c && (!fifo_full || pop_c);
        drop_c = good_c && fifo_full && !pop_c;

        framing_error_d = load_c ? frm_bad_q : framing_error_q;
        parity_error_d  = load_c ? par_bad_q : parity_error_q;

        overrun_d = overrun_q;
        if (data_read) begin
            overrun_d = 1'b0;
        end
        if (drop_c) begin
            overrun_d = 1'b1;
        end

        data_ready_d = push_c || (fifo_cnt > CNT_W'(1)) ||
                       ((fifo_cnt == CNT_W'(1)) && !pop_c);

        // Track the post-edge head; an emptied FIFO leaves the last popped byte visible.
        rx_data_d = rx_data_q;
        if (!fifo_empty) begin
            rx_data_d = fifo_head;
        end
        if (pop_c) begin
            if (fifo_cnt > CNT_W'(1)) begin
                rx_data_d = fifo_next_head;
            end else if (push_c) begin
                rx_data_d = shift_q;
            end else begin
                rx_data_d = rx_data_q;
            end
        end else if (push_c && fifo_empty) begin
            rx_data_d = shift_q;
        end
    end

    // All receiver state; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            prev_q          <= 1'b1;
            state_q         <= IDLE;
            timer_q         <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_bad_q       <= 1'b0;
            frm_bad_q       <= 1'b0;
            rx_data_q       <= '1;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            parity_error_q  <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            sync1_q         <= serial_in;
            sync2_q         <= sync1_q;
            prev_q          <= sync2_q;
            state_q         <= state_d;
            timer_q         <= timer_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            par_bad_q       <= par_bad_d;
            frm_bad_q       <= frm_bad_d;
            rx_data_q       <= rx_data_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
            parity_error_q  <= parity_error_d;
            overrun_q       <= overrun_d;
        end
    end

    rcv_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (shift_q),
        .pop       (pop_c),
        .head      (fifo_head),
        .next_head (fifo_next_head),
        .count     (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/uart_rcv_fifo.md
# uart_rcv_fifo

Parametrised serial receive block. Deserialises an asynchronous start/data/parity/stop frame on `serial_in` with mid-bit oversampling and checks framing and parity. Good frames are buffered in a small receive FIFO so a bus-side slave can drain several bytes per access burst. It sits between the pad-side serial line and the peripheral's register/slave interface, replacing the fixed 8-bit, single-buffer receiver.

## Interface
Parameters:
- `DATA_BITS`, default 8: payload bits per frame, legal 5..9.
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit, legal ≥4.
- `PARITY_EN`, default 0: 1 inserts one parity bit after the data bits.
- `STOP_BITS`, default 1: stop bits checked, legal 1 or 2.
- `FIFO_DEPTH`, default 4: receive FIFO entries, a power of 2 and ≥2.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `serial_in`, input, 1: raw serial line; idle high.
- `parity_odd`, input, 1: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.
- `data_read`, input, 1: one-cycle pop request.
- `rx_data`, output, `DATA_BITS`: FIFO head.
- `data_ready`, output, 1: FIFO non-empty.
- `fifo_count`, output, `$clog2(FIFO_DEPTH+1)`: number of occupied entries.
- `framing_error`, output, 1: the last completed frame had a 0 stop bit.
- `parity_error`, output, 1: the last completed frame had a parity mismatch.
- `overrun_error`, output, 1: sticky; a good frame was dropped because the FIFO was full.

## Operation
Reset values:
- `rx_data` all ones.
- `data_ready`, `fifo_count`, and all three error flags 0.
- FSM in IDLE.
- Synchronizer flops at 1.

Input path: `serial_in` passes through a 2-flop synchronizer; all logic uses the synchronized signal.

FSM states:
- IDLE: a 1→0 edge on the synchronized line moves to START. A low level alone does not start a frame.
- START: waits `CLKS_PER_BIT/2` (floor) cycles, then samples. Low moves to DATA; high is a false start and returns to IDLE with no flag changes.
- DATA: samples every `CLKS_PER_BIT` cycles, LSB first, for `DATA_BITS` samples. Then moves to PARITY if `PARITY_EN`, otherwise to STOP.
- PARITY: one sample. Expected value is XOR of the data bits, inverted when `parity_odd`=1.
- STOP: `STOP_BITS` samples spaced `CLKS_PER_BIT` apart. Any 0 sample marks a framing error.
- LOAD: one cycle, then IDLE. No wait for the end of the stop bit, so the next start edge is caught early.

LOAD rules:
- Both error flags are updated every frame: each is set if its condition occurred and cleared otherwise.
- A frame with a framing or parity error is discarded; the FIFO is unchanged.
- A good frame with the FIFO not full is pushed.
- A good frame with the FIFO full and no simultaneous pop is dropped and `overrun_error` is set. A simultaneous pop frees the slot, the frame is pushed, and no overrun is flagged.

Read side:
- `data_read` with the FIFO non-empty pops the head.
- `data_read` with the FIFO empty is ignored.
- `data_read` also clears `overrun_error`. If a new overrun occurs in the same cycle, the set wins.
- When the FIFO becomes empty, `rx_data` holds the last popped value.

Bit timer: modulo-`CLKS_PER_BIT` down-counter, reloaded on each sample. The bit counter width is `$clog2(DATA_BITS+1)`.

Reset mid-frame: the frame is abandoned and the FIFO is flushed.

Rate tolerance: at `CLKS_PER_BIT`=10, all frames with bit periods between 0.96× and 1.04× nominal must be received correctly.

## Timing
- Start sample: 2 cycles of synchronizer latency plus `CLKS_PER_BIT/2` cycles after the line falls.
- Data bit n: sampled `(n+1)*CLKS_PER_BIT` cycles after the start sample.
- Push: `data_ready`, `rx_data`, `fifo_count` and the error flags update on the edge after the final stop sample.
- Pop: on the clock edge that samples `data_read` high, `rx_data` advances to the next entry and `fifo_count` decrements. `data_ready` falls on that edge if that pop empties the FIFO.
- Push and pop in the same cycle: `fifo_count` is unchanged.

## Structure
- Package `uart_rcv_pkg` holds the FSM state enum (IDLE, START, DATA, PARITY, STOP, LOAD) and a parity helper function.
- Sub-module `rcv_fifo` is a synchronous FIFO with parameters `WIDTH` and `DEPTH`. It provides push/pop, full/empty, a count output and a show-ahead head.
- The synchronizer, timer, shift register and FSM live in the top module.

## Test plan
- Reset and 8'hF0 frame at nominal rate, then a pulse on `data_read`:
  - Before the pop: `rx_data`=F0, `data_ready`=1, all error flags 0.
  - After the pop: `data_ready`=0.
- 8'hF0 sent at 0.96× and at 1.04× bit period: each is received as F0 with no errors.
- 8'hDD with stop bit 0, then 8'hAA with a good stop bit:
  - After the first frame: `framing_error`=1, `fifo_count`=0.
  - After the second frame: `framing_error`=0, `rx_data`=AA.
- `PARITY_EN`=1, `parity_odd`=0, frame 8'h01 with parity bit 0: `parity_error`=1 and the frame is dropped. The same frame with parity bit 1 is accepted.
- `FIFO_DEPTH`=4, five good frames 01..05 with no reads:
  - After the fifth frame: `fifo_count`=4, `overrun_error`=1.
  - Pops return 01, 02, 03, 04; the first pop clears the overrun flag.
- `rst` asserted halfway through DATA: all outputs return to reset values. The next frame 8'h3C is received correctly.
